// File: rtl/sc_pulse_sched_if.sv
// Request/window bus between event sources and the pulse scheduler.
// The scheduler takes the slave modport; the event side takes the master modport.
interface sc_pulse_sched_if #(
    parameter int unsigned N_CH  = 4,
    parameter int unsigned CNT_W = 16
);
    localparam int unsigned GID_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    logic                enable;
    logic [N_CH-1:0]     pulse_in;
    logic [CNT_W-1:0]    win_len;
    logic [N_CH-1:0]     bit_stream;
    logic                busy;
    logic [GID_W-1:0]    grant_id;
    logic [N_CH-1:0]     pend;
    logic [N_CH-1:0]     drop_pulse;

    modport master (
        output enable, pulse_in, win_len,
        input  bit_stream, busy, grant_id, pend, drop_pulse
    );

    modport slave (
        input  enable, pulse_in, win_len,
        output bit_stream, busy, grant_id, pend, drop_pulse
    );
endinterface

// File: rtl/sc_pulse_sched.sv
// Round-robin scheduler sharing one pulse-stretching window among N_CH channels.
// Each request is latched as pending and later served as a window of win_len
// cycles on its bit_stream bit, followed by GAP_LEN guard cycles.
// Optional macro SC_PULSE_SCHED_RETRIG_EN: a new request on the channel that
// currently owns the window reloads the window counter instead of queueing.
module sc_pulse_sched #(
    parameter int unsigned N_CH    = 4,
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned GAP_LEN = 2
) (
    input  logic                clk,
    input  logic                rst,
    sc_pulse_sched_if.slave     sched_if
);

    localparam int unsigned GID_W = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int unsigned GAP_W = (GAP_LEN > 0) ? $clog2(GAP_LEN + 1) : 1;
    localparam logic [GID_W-1:0] LAST_RST = GID_W'(N_CH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACTIVE,
        S_GAP
    } state_e;

    state_e             state_q, state_d;
    logic [N_CH-1:0]    pulse_q;
    logic [N_CH-1:0]    pend_q, pend_d;
    logic [N_CH-1:0]    drop_q, drop_d;
    logic [N_CH-1:0]    bits_q, bits_d;
    logic               busy_q, busy_d;
    logic [GID_W-1:0]   gid_q, gid_d;
    logic [GID_W-1:0]   last_q, last_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [GAP_W-1:0]   gap_q, gap_d;

    logic [N_CH-1:0]    ev;
    logic [CNT_W-1:0]   eff_len;
    logic [N_CH-1:0]    clr;
    logic               retrig;
    logic               ap;
    logic               pick_vld;
    logic [GID_W-1:0]   pick;
    int unsigned        idx;

    assign ev      = sched_if.pulse_in & ~pulse_q;
    assign eff_len = (sched_if.win_len == '0) ? CNT_W'(1) : sched_if.win_len;

    // Round-robin pick: first pending channel strictly after last_q, wrapping.
    always_comb begin
        pick_vld = 1'b0;
        pick     = last_q;
        idx      = 0;
        for (int unsigned k = 1; k <= N_CH; k++) begin
            idx = 32'(last_q) + k;
            if (idx >= N_CH) begin
                idx = idx - N_CH;
            end
            if (!pick_vld && pend_q[GID_W'(idx)]) begin
                pick_vld = 1'b1;
                pick     = GID_W'(idx);
            end
        end
    end

    // Window FSM: next state, counters and next registered outputs.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gap_d   = gap_q;
        bits_d  = '0;
        busy_d  = 1'b0;
        gid_d   = gid_q;
        last_d  = last_q;
        clr     = '0;
        retrig  = 1'b0;
        ap      = 1'b0;

        case (state_q)
            S_IDLE: begin
                ap = 1'b1;
            end
            S_ACTIVE: begin
`ifdef SC_PULSE_SCHED_RETRIG_EN
                retrig = ev[last_q];
`endif
                if (retrig) begin
                    cnt_d  = eff_len;
                    bits_d = bits_q;
                    busy_d = 1'b1;
                end else if (cnt_q == CNT_W'(1)) begin
                    if (GAP_LEN > 0) begin
                        state_d = S_GAP;
                        gap_d   = GAP_W'(GAP_LEN);
                    end else begin
                        ap = 1'b1;
                    end
                end else begin
                    cnt_d  = cnt_q - CNT_W'(1);
                    bits_d = bits_q;
                    busy_d = 1'b1;
                end
            end
            S_GAP: begin
                if (gap_q == GAP_W'(1)) begin
                    ap = 1'b1;
                end else begin
                    gap_d = gap_q - GAP_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (ap) begin
            if (sched_if.enable && pick_vld) begin
                state_d = S_ACTIVE;
                clr     = N_CH'(1) << pick;
                last_d  = pick;
                gid_d   = pick;
                cnt_d   = eff_len;
                bits_d  = N_CH'(1) << pick;
                busy_d  = 1'b1;
            end else begin
                state_d = S_IDLE;
            end
        end
    end

    // Pending flags and drop strobes; a grant-clear coinciding with a new edge keeps the flag.
    always_comb begin
        pend_d = pend_q & ~clr;
        drop_d = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (ev[i] && !(retrig && (GID_W'(i) == last_q))) begin
                if (pend_q[i] && !clr[i]) begin
                    drop_d[i] = 1'b1;
                end
                pend_d[i] = 1'b1;
            end
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            pulse_q <= '0;
            pend_q  <= '0;
            drop_q  <= '0;
            bits_q  <= '0;
            busy_q  <= 1'b0;
            gid_q   <= '0;
            last_q  <= LAST_RST;
            cnt_q   <= '0;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            pulse_q <= sched_if.pulse_in;
            pend_q  <= pend_d;
            drop_q  <= drop_d;
            bits_q  <= bits_d;
            busy_q  <= busy_d;
            gid_q   <= gid_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
        end
    end

    assign sched_if.bit_stream = bits_q;
    assign sched_if.busy       = busy_q;
    assign sched_if.grant_id   = gid_q;
    assign sched_if.pend       = pend_q;
    assign sched_if.drop_pulse = drop_q;

endmodule

// File: tb/tb_sc_pulse_sched.sv
// Testbench for sc_pulse_sched: directed scenarios followed by random traffic,
// every cycle compared against a window/queue reference model.
module tb_sc_pulse_sched;

    localparam int unsigned N_CH    = 4;
    localparam int unsigned CNT_W   = 16;
    localparam int unsigned GAP_LEN = 2;
`ifdef SC_PULSE_SCHED_RETRIG_EN
    localparam bit RETRIG = 1'b1;
`else
    localparam bit RETRIG = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;

    sc_pulse_sched_if #(.N_CH(N_CH), .CNT_W(CNT_W)) ifc ();

    sc_pulse_sched #(.N_CH(N_CH), .CNT_W(CNT_W), .GAP_LEN(GAP_LEN)) dut (
        .clk      (clk),
        .rst      (rst),
        .sched_if (ifc)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: pending queue per channel, remaining window / gap cycles.
    int m_pend [N_CH];
    bit m_prev [N_CH];
    bit m_drop [N_CH];
    int m_cur, m_left, m_gap, m_last, m_gid;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        for (int i = 0; i < N_CH; i++) begin
            m_pend[i] = 0;
            m_prev[i] = 1'b0;
            m_drop[i] = 1'b0;
        end
        m_cur  = 0;
        m_left = 0;
        m_gap  = 0;
        m_last = N_CH - 1;
        m_gid  = 0;
    endtask

    task automatic model_step(input bit r, input bit en, input logic [N_CH-1:0] p, input int wl);
        bit ev [N_CH];
        int old_pend [N_CH];
        int eff, old_left, old_gap, g;
        bit rt, ap;
        if (r) begin
            model_reset();
            return;
        end
        eff = (wl == 0) ? 1 : wl;
        for (int i = 0; i < N_CH; i++) begin
            ev[i]       = p[i] && !m_prev[i];
            old_pend[i] = m_pend[i];
        end
        old_left = m_left;
        old_gap  = m_gap;
        rt = RETRIG && (old_left > 0) && ev[m_cur];
        ap = (old_left == 0 && old_gap == 0) || (old_left == 1 && GAP_LEN == 0 && !rt) || (old_gap == 1);
        g = -1;
        if (ap && en) begin
            for (int k = 1; k <= N_CH; k++) begin
                int c;
                c = (m_last + k) % N_CH;
                if (g < 0 && old_pend[c] != 0) g = c;
            end
        end
        if (rt) m_left = eff;
        else if (old_left > 0) begin
            m_left = old_left - 1;
            if (m_left == 0 && GAP_LEN > 0) m_gap = GAP_LEN;
        end else if (old_gap > 0) m_gap = old_gap - 1;
        if (g >= 0) begin
            m_cur = g; m_left = eff; m_gap = 0; m_last = g; m_gid = g; m_pend[g] = 0;
        end
        for (int i = 0; i < N_CH; i++) begin
            m_drop[i] = 1'b0;
            if (ev[i] && !(rt && i == m_cur)) begin
                if (old_pend[i] != 0 && i != g) m_drop[i] = 1'b1;
                m_pend[i] = 1;
            end
            m_prev[i] = p[i];
        end
    endtask

    task automatic compare_all();
        logic [N_CH-1:0] eb, ep, ed;
        eb = (m_left > 0) ? (N_CH'(1) << m_cur) : '0;
        for (int i = 0; i < N_CH; i++) begin
            ep[i] = (m_pend[i] != 0);
            ed[i] = m_drop[i];
        end
        check("bit_stream", 32'(ifc.bit_stream), 32'(eb));
        check("busy",       32'(ifc.busy),       32'(m_left > 0));
        check("grant_id",   32'(ifc.grant_id),   32'(m_gid));
        check("pend",       32'(ifc.pend),       32'(ep));
        check("drop_pulse", 32'(ifc.drop_pulse), 32'(ed));
    endtask

    // One clock: drive inputs, step the model on the edge, compare mid-cycle.
    task automatic tick(input bit r, input bit en, input logic [N_CH-1:0] p, input int wl);
        rst          = r;
        ifc.enable   = en;
        ifc.pulse_in = p;
        ifc.win_len  = CNT_W'(wl);
        @(posedge clk);
        model_step(r, en, p, wl);
        @(negedge clk);
        compare_all();
    endtask

    initial begin
        int c;
        logic [N_CH-1:0] p;
        bit en, r;
        int wl;

        rst = 1'b1;
        ifc.enable = 1'b0;
        ifc.pulse_in = '0;
        ifc.win_len = '0;
        model_reset();

        // Reset state
        tick(1, 0, 4'b0000, 5);
        tick(1, 0, 4'b0000, 5);
        check("rst_bits", 32'(ifc.bit_stream), 32'h0);
        check("rst_gid",  32'(ifc.grant_id),   32'h0);
        check("rst_pend", 32'(ifc.pend),       32'h0);

        // Single request on ch1, window 5
        tick(0, 1, 4'b0000, 5);
        tick(0, 1, 4'b0010, 5);
        check("single_pend", 32'(ifc.pend), 32'h2);
        for (int k = 1; k <= 7; k++) begin
            tick(0, 1, (k < 3) ? 4'b0010 : 4'b0000, 5);
            check("single_bits", 32'(ifc.bit_stream), (k <= 5) ? 32'h2 : 32'h0);
            check("single_busy", 32'(ifc.busy), (k <= 5) ? 32'h1 : 32'h0);
        end
        check("single_gid", 32'(ifc.grant_id), 32'h1);

        // Simultaneous ch0 + ch2 after reset
        tick(1, 1, 4'b0000, 5);
        tick(0, 1, 4'b0000, 5);
        tick(0, 1, 4'b0101, 5);
        for (int k = 1; k <= 13; k++) begin
            tick(0, 1, 4'b0101, 5);
            check("simul_bits", 32'(ifc.bit_stream),
                  (k <= 5) ? 32'h1 : ((k >= 8 && k <= 12) ? 32'h4 : 32'h0));
        end
        for (int k = 0; k < 3; k++) tick(0, 1, 4'b0000, 5);

        // Second ch3 edge while pending and ch0 active
        tick(0, 1, 4'b0001, 8);
        tick(0, 1, 4'b0001, 8);
        tick(0, 1, 4'b1001, 8);
        tick(0, 1, 4'b0001, 8);
        tick(0, 1, 4'b1001, 8);
        check("dbl_drop_hi", 32'(ifc.drop_pulse), 32'h8);
        tick(0, 1, 4'b0001, 8);
        check("dbl_drop_lo", 32'(ifc.drop_pulse), 32'h0);
        c = 0;
        for (int k = 0; k < 25; k++) begin
            tick(0, 1, 4'b0000, 8);
            if (ifc.bit_stream[3]) c++;
        end
        check("dbl_ch3_cycles", 32'(c), 32'd8);

        // win_len = 0 behaves as a 1-cycle window
        tick(0, 1, 4'b0100, 0);
        c = 0;
        for (int k = 0; k < 6; k++) begin
            tick(0, 1, 4'b0100, 0);
            if (ifc.bit_stream[2]) c++;
        end
        check("wl0_cycles", 32'(c), 32'd1);

        // enable low holds the pending request
        tick(0, 1, 4'b0000, 5);
        tick(0, 0, 4'b0100, 5);
        for (int k = 0; k < 20; k++) tick(0, 0, 4'b0100, 5);
        check("en0_busy", 32'(ifc.busy), 32'h0);
        check("en0_pend", 32'(ifc.pend), 32'h4);
        tick(0, 1, 4'b0100, 5);
        check("en1_bits", 32'(ifc.bit_stream), 32'h4);
        for (int k = 0; k < 8; k++) tick(0, 1, 4'b0000, 5);

        // Reset in the middle of a window discards pending work
        tick(0, 1, 4'b0010, 5);
        tick(0, 1, 4'b0010, 5);
        tick(0, 1, 4'b1010, 5);
        tick(0, 1, 4'b1010, 5);
        tick(1, 1, 4'b0000, 5);
        check("mid_rst_bits", 32'(ifc.bit_stream), 32'h0);
        check("mid_rst_busy", 32'(ifc.busy),       32'h0);
        check("mid_rst_pend", 32'(ifc.pend),       32'h0);
        tick(0, 1, 4'b0000, 5);
        tick(0, 1, 4'b0101, 5);
        tick(0, 1, 4'b0101, 5);
        check("post_rst_first", 32'(ifc.bit_stream), 32'h1);
        for (int k = 0; k < 15; k++) tick(0, 1, 4'b0000, 5);

        // Own-channel edge three cycles into a 5-cycle window
        tick(0, 1, 4'b0010, 5);
        c = 0;
        for (int k = 1; k <= 16; k++) begin
            tick(0, 1, (k == 4) ? 4'b0010 : 4'b0000, 5);
            if (ifc.bit_stream[1]) c++;
            if (k == 4) check("retrig_pend1", 32'(ifc.pend[1]), RETRIG ? 32'h0 : 32'h1);
        end
        check("retrig_cycles", 32'(c), RETRIG ? 32'd8 : 32'd10);

        // Random traffic
        p = '0;
        for (int k = 0; k < 700; k++) begin
            p  = p ^ N_CH'($urandom & $urandom);
            en = ($urandom_range(0, 9) != 0);
            r  = ($urandom_range(0, 199) == 0);
            wl = ($urandom_range(0, 15) == 0) ? $urandom_range(20, 40) : $urandom_range(0, 6);
            tick(r, en, p, wl);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
